// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned     XLEN        = 32;
    localparam int unsigned     INSTR_BYTES = 4;
    localparam int unsigned     FIFO_DEPTH  = 2;
    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ      = 2'd1,
        WAIT     = 2'd2,
        DRAIN    = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic            fault;
    } fetch_entry_t;

    // Sequential PC; wraps naturally at 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Instruction memory request/response bus for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );

endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Two-entry fetch FIFO with synchronous flush; head is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t r_mem [FIFO_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push_ok;
    logic         w_pop_ok;

    // A push into a full buffer is legal only when the head leaves the same cycle.
    assign w_pop_ok  = pop && (r_count != 2'd0);
    assign w_push_ok = push && ((r_count != 2'(FIFO_DEPTH)) || w_pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : fetch_buffer
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetch stage - owns the PC, issues single-outstanding imem
//               requests and feeds the IF/ID register through a 2-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_if.master               imem,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] instr_fetch,
    output logic [DATA_WIDTH-1:0] pc_fetch,
    output logic [DATA_WIDTH-1:0] npc_fetch,
    output logic                  fetch_fault
);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_halt;
    logic                  r_fault_pend;

    logic                  w_misaligned;
    logic                  w_accept;
    logic                  w_rsp_take;
    logic                  w_outstanding;
    logic                  w_room_idle;
    logic                  w_room_wait;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fetch_valid;
    logic [1:0]            w_count;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head;

    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= REQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_room_idle   = (w_count < 2'd2) || w_pop;
        w_room_wait   = (w_count == 2'd0) || ((w_count == 2'd1) && w_pop);
        w_outstanding = 1'b0;

        case (r_state)
            REQ_IDLE: if (!r_halt && w_room_idle) w_state_nxt = REQ;
            REQ:      if (imem.imem_req_ready)    w_state_nxt = WAIT;
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    w_state_nxt = w_room_wait ? REQ : REQ_IDLE;
                end
            end
            DRAIN: begin
                if (imem.imem_rsp_valid) begin
                    w_state_nxt = r_halt ? REQ_IDLE : REQ;
                end
            end
            default: w_state_nxt = REQ_IDLE;
        endcase

        // A response arriving in the redirect cycle is consumed and dropped here,
        // so only a still-pending request needs the DRAIN state.
        if (redirect_valid) begin
            w_outstanding = ((r_state == REQ) && imem.imem_req_ready)
                         || (((r_state == WAIT) || (r_state == DRAIN)) && !imem.imem_rsp_valid);
            if (w_outstanding) begin
                w_state_nxt = DRAIN;
            end else if (w_misaligned) begin
                w_state_nxt = REQ_IDLE;
            end else begin
                w_state_nxt = REQ;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs and request/response glue
    // ------------------------------------------------------------------------
    always_comb begin
        imem.imem_req_valid = (r_state == REQ);
        imem.imem_req_addr  = r_pc;
        w_accept            = (r_state == REQ) && imem.imem_req_ready;
        w_rsp_take          = (r_state == WAIT) && imem.imem_rsp_valid;
        w_pop               = w_fetch_valid && !stall && !redirect_valid;
        w_push              = !redirect_valid && (r_fault_pend || w_rsp_take);

        // r_pc has already advanced past the in-flight request.
        if (r_fault_pend) begin
            w_push_entry.instr = NOP_INSTR;
            w_push_entry.pc    = r_pc;
            w_push_entry.npc   = next_pc(r_pc);
            w_push_entry.fault = 1'b1;
        end else begin
            w_push_entry.instr = imem.imem_rsp_err ? NOP_INSTR : imem.imem_rsp_data;
            w_push_entry.pc    = r_pc - DATA_WIDTH'(INSTR_BYTES);
            w_push_entry.npc   = r_pc;
            w_push_entry.fault = imem.imem_rsp_err;
        end
    end

    // ------------------------------------------------------------------------
    // PC and misaligned-redirect bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= RESET_PC;
            r_halt       <= 1'b0;
            r_fault_pend <= 1'b0;
        end else begin
            r_fault_pend <= 1'b0;
            if (redirect_valid) begin
                r_pc         <= redirect_pc;
                r_halt       <= w_misaligned;
                r_fault_pend <= w_misaligned;
            end else if (w_accept) begin
                r_pc <= next_pc(r_pc);
            end
        end
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_count)
    );

    assign w_fetch_valid = (w_count != 2'd0);
    assign fetch_valid   = w_fetch_valid;
    assign instr_fetch   = w_head.instr;
    assign pc_fetch      = w_head.pc;
    assign npc_fetch     = w_head.npc;
    assign fetch_fault   = w_head.fault;

endmodule : fetch_unit
`default_nettype wire
